// File: rtl/apb_cfg_master.sv
// apb_cfg_master: APB3 requester bridging a valid/ready request/response port onto the
// core-complex APB config bus. One transfer at a time: SETUP, ACCESS (with PREADY wait
// states), then a held response until consumed.
// Optional feature: define APB_MST_TIMEOUT_EN to abort an ACCESS phase that sees PREADY low
// for TIMEOUT_CYCLES cycles; the response then carries rsp_err=1 and timeout_flag latches.
module apb_cfg_master #(
    parameter int unsigned APB_ADDR_WIDTH = 12,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                      PCLK,
    input  logic                      PRESETn,
    // request port
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [APB_ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]               req_wdata,
    // response port
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [31:0]               rsp_rdata,
    output logic                      rsp_err,
    output logic                      timeout_flag,
    // APB requester
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [31:0]               PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [31:0]               PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR
);

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StAccess,
        StResp
    } state_e;

    state_e                    state_q, state_d;
    logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
    logic [31:0]               pwdata_q, pwdata_d;
    logic                      pwrite_q, pwrite_d;
    logic [31:0]               rsp_rdata_q, rsp_rdata_d;
    logic                      rsp_err_q, rsp_err_d;

`ifdef APB_MST_TIMEOUT_EN
    // Counter only ever needs to hold TIMEOUT_CYCLES-1; one spare value keeps the width safe.
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic            tmo_flag_q, tmo_flag_d;
`endif

    // Next-state and datapath updates for the single-outstanding transfer sequencer.
    always_comb begin
        state_d     = state_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pwrite_d    = pwrite_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef APB_MST_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        tmo_flag_d  = tmo_flag_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    paddr_d  = req_addr;
                    pwdata_d = req_wdata;
                    pwrite_d = req_write;
                    state_d  = StSetup;
                end
            end

            StSetup: begin
                state_d = StAccess;
`ifdef APB_MST_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
            end

            StAccess: begin
                // PREADY wins over a timeout landing in the same cycle.
                if (PREADY) begin
                    rsp_rdata_d = pwrite_q ? 32'h0 : PRDATA;
                    rsp_err_d   = PSLVERR;
                    state_d     = StResp;
                end
`ifdef APB_MST_TIMEOUT_EN
                else if (tmo_cnt_q == CntLast) begin
                    rsp_rdata_d = 32'h0;
                    rsp_err_d   = 1'b1;
                    tmo_flag_d  = 1'b1;
                    state_d     = StResp;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + CntW'(1);
                end
`endif
            end

            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset drops the bus and discards any transfer in flight.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= StIdle;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pwrite_q    <= pwrite_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

`ifdef APB_MST_TIMEOUT_EN
    // Wait-state counter and sticky timeout flag.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            tmo_cnt_q  <= '0;
            tmo_flag_q <= 1'b0;
        end else begin
            tmo_cnt_q  <= tmo_cnt_d;
            tmo_flag_q <= tmo_flag_d;
        end
    end

    assign timeout_flag = tmo_flag_q;
`else
    assign timeout_flag = 1'b0;
`endif

    // Handshake and bus controls decode straight from state so reset removes them at once.
    assign req_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StResp);
    assign PSEL      = (state_q == StSetup) || (state_q == StAccess);
    assign PENABLE   = (state_q == StAccess);
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign PWRITE    = pwrite_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    // Protocol invariants.
    a_no_req_and_rsp : assert property (@(posedge PCLK) disable iff (!PRESETn)
        !(rsp_valid && req_ready));

    a_setup_then_access : assert property (@(posedge PCLK) disable iff (!PRESETn)
        (PSEL && !PENABLE) |=> (PSEL && PENABLE));

    a_access_stable : assert property (@(posedge PCLK) disable iff (!PRESETn)
        (PSEL && PENABLE) |-> ($stable(PADDR) && $stable(PWDATA) && $stable(PWRITE)));

    a_rsp_hold : assert property (@(posedge PCLK) disable iff (!PRESETn)
        (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_rdata) && $stable(rsp_err)));

endmodule
